// File: rtl/mmio_arbiter_pkg.sv
// Shared definitions for the two-requester MMIO arbiter: FSM encoding,
// requester indices and the data returned when a read times out.
package mmio_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_READ = 2'd2,
    ST_RESPOND   = 2'd3
  } state_t;

  localparam logic REQ_D = 1'b0;
  localparam logic REQ_I = 1'b1;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mmio_arbiter.sv
// Arbitrates a data-side and an instruction-side requester onto one MMIO
// command port, one transaction in flight at a time, with a read timeout.
module mmio_arbiter
  import mmio_arbiter_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_cmd_start,
  input  logic        d_cmd_write,
  output logic        d_cmd_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_rdata_valid,
  input  logic        i_cmd_start,
  input  logic        i_cmd_write,
  output logic        i_cmd_ready,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] i_rdata,
  output logic        i_rdata_valid,
  output logic        mem_cmd_start,
  output logic        mem_cmd_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_cmd_ready,
  input  logic        mem_rdata_valid,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_t            state_reg, state_next;
  logic              hold_write_reg;
  logic [31:0]       hold_addr_reg;
  logic [31:0]       hold_wdata_reg;
  logic              winner_reg;
  logic              last_grant_reg;
  logic [CNT_W-1:0]  wait_cnt_reg;
  logic [31:0]       d_rdata_reg;
  logic [31:0]       i_rdata_reg;

  logic              accept;
  logic              grant;
  logic              capture;
  logic [31:0]       capture_data;

  always_comb begin
    state_next   = state_reg;
    accept       = 1'b0;
    grant        = REQ_D;
    capture      = 1'b0;
    capture_data = mem_rdata;
    case (state_reg)
      ST_IDLE: begin
        if (d_cmd_start || i_cmd_start) begin
          accept     = 1'b1;
          state_next = ST_ISSUE;
          if (d_cmd_start && i_cmd_start) begin
            // Fixed priority keeps D; round robin hands the tie to whoever lost last time.
            grant = (ROUND_ROBIN != 0 && last_grant_reg == REQ_D) ? REQ_I : REQ_D;
          end else begin
            grant = d_cmd_start ? REQ_D : REQ_I;
          end
        end
      end
      ST_ISSUE: begin
        if (mem_cmd_ready) begin
          state_next = hold_write_reg ? ST_IDLE : ST_WAIT_READ;
        end
      end
      ST_WAIT_READ: begin
        if (mem_rdata_valid) begin
          capture    = 1'b1;
          state_next = ST_RESPOND;
        end else if (wait_cnt_reg >= CNT_MAX) begin
          capture      = 1'b1;
          capture_data = TIMEOUT_DATA;
          state_next   = ST_RESPOND;
        end
      end
      ST_RESPOND: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      hold_write_reg <= 1'b0;
      hold_addr_reg  <= '0;
      hold_wdata_reg <= '0;
      winner_reg     <= REQ_D;
      last_grant_reg <= REQ_I;
      wait_cnt_reg   <= '0;
      d_rdata_reg    <= '0;
      i_rdata_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        hold_write_reg <= (grant == REQ_D) ? d_cmd_write : i_cmd_write;
        hold_addr_reg  <= (grant == REQ_D) ? d_addr : i_addr;
        hold_wdata_reg <= (grant == REQ_D) ? d_wdata : i_wdata;
        winner_reg     <= grant;
        last_grant_reg <= grant;
      end
      if (state_reg == ST_ISSUE) begin
        wait_cnt_reg <= '0;
      end else if (state_reg == ST_WAIT_READ && !capture && wait_cnt_reg < CNT_MAX) begin
        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
      end
      if (capture) begin
        if (winner_reg == REQ_D) begin
          d_rdata_reg <= capture_data;
        end else begin
          i_rdata_reg <= capture_data;
        end
      end
    end
  end

  assign d_cmd_ready   = (state_reg == ST_IDLE);
  assign i_cmd_ready   = (state_reg == ST_IDLE);
  assign d_rdata       = d_rdata_reg;
  assign i_rdata       = i_rdata_reg;
  assign d_rdata_valid = (state_reg == ST_RESPOND) && (winner_reg == REQ_D);
  assign i_rdata_valid = (state_reg == ST_RESPOND) && (winner_reg == REQ_I);
  // The command is only offered downstream in the cycle it is actually taken.
  assign mem_cmd_start = (state_reg == ST_ISSUE) && mem_cmd_ready;
  assign mem_cmd_write = hold_write_reg;
  assign mem_addr      = hold_addr_reg;
  assign mem_wdata     = hold_wdata_reg;

endmodule

// File: doc/mmio_arbiter.md
MMIO_ARBITER -- requirements
Module: mmio_arbiter

Interface
REQ-001 Parameter ROUND_ROBIN, default 1: 1 = alternate grant on simultaneous requests; 0 = requester D always wins.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum wait cycles for read data after issue.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 d_cmd_start  input  1  data-side request strobe.
REQ-006 d_cmd_write  input  1  data-side request is a write.
REQ-007 d_cmd_ready  output  1  data-side may issue.
REQ-008 d_addr, d_wdata  input  32 each  data-side address and write data.
REQ-009 d_rdata  output  32  data-side read data.
REQ-010 d_rdata_valid  output  1  one-cycle pulse qualifying d_rdata.
REQ-011 i_cmd_start, i_cmd_write, i_cmd_ready, i_addr, i_wdata, i_rdata, i_rdata_valid: instruction-side port; same directions and widths as d_*.
REQ-012 mem_cmd_start, mem_cmd_write  output  1 each  downstream MMIO command.
REQ-013 mem_addr, mem_wdata  output  32 each  downstream address and write data.
REQ-014 mem_cmd_ready, mem_rdata_valid  input  1 each; mem_rdata  input  32  downstream status and read data.

Function
REQ-015 States: IDLE, ISSUE, WAIT_READ, RESPOND.
REQ-016 d_cmd_ready and i_cmd_ready are both 1 only in IDLE; 0 in all other states.
REQ-017 In IDLE, a strobe with its ready high is accepted: cmd_write, addr and wdata latched into holding registers, winner index recorded, next state ISSUE.
REQ-018 Simultaneous strobes with ROUND_ROBIN=1: grant the requester not granted last; first grant after reset goes to D.
REQ-019 Simultaneous strobes with ROUND_ROBIN=0: D wins; the losing strobe is dropped and must be re-asserted by its requester.
REQ-020 In ISSUE: mem_cmd_start=1 with the latched fields while mem_cmd_ready=1; the cycle mem_cmd_ready=1 is the issue cycle. Write -> IDLE; read -> WAIT_READ with a wait counter cleared to 0.
REQ-021 While mem_cmd_ready=0 in ISSUE, mem_cmd_start stays 0 and the latched fields are held.
REQ-022 In WAIT_READ: mem_rdata_valid=1 captures mem_rdata into the winner's rdata register -> RESPOND; otherwise the counter increments.
REQ-023 When the counter reaches TIMEOUT_CYCLES without valid, capture 32'hDEADBEEF -> RESPOND.
REQ-024 In RESPOND: the winner's rdata_valid=1 for exactly one cycle -> IDLE; the other side's rdata_valid stays 0.
REQ-025 Each rdata register holds its value until that side's next read completes.
REQ-026 Write latency: issue cycle is the earliest one cycle after acceptance; no rdata_valid pulse for writes.
REQ-027 Minimum read latency: acceptance to rdata_valid is 3 cycles. Back-to-back acceptance is possible in the cycle after RESPOND or after a write issue.
REQ-028 mem_cmd_write, mem_addr and mem_wdata are driven from the holding registers in every state; mem_cmd_start is 1 only as in REQ-020.
REQ-029 The wait counter is TIMEOUT_CYCLES-wide enough with no overflow; it saturates at TIMEOUT_CYCLES.

Reset
REQ-030 rst=1 at any clock edge: state to IDLE, abort any in-flight transaction with no rdata_valid pulse, and set the last-grant register so D wins next.
REQ-031 rst=1 also clears to 0: holding registers, both rdata registers, both rdata_valid outputs, mem_cmd_start and the wait counter.
REQ-032 d/i_cmd_ready are 1 in the first cycle after rst deasserts.

Structure
REQ-033 The shared package holds the state encoding, the requester index constants (REQ_D, REQ_I) and the timeout data constant 32'hDEADBEEF.
REQ-034 Single module; no sub-module.

Verification
REQ-035 Both sides idle, D reads 0xFF000010 with mem_rdata_valid on the first WAIT_READ cycle and mem_rdata=0x41 -> d_rdata=0x41 and d_rdata_valid pulses 3 cycles after acceptance; i_rdata_valid stays 0.
REQ-036 D and I strobe together four times, ROUND_ROBIN=1 -> grants D, I, D, I; with ROUND_ROBIN=0 -> D every time.
REQ-037 I writes 0x12345678 to 0x100 with mem_cmd_ready=0 for 5 cycles -> mem_cmd_start is asserted only in the 6th ISSUE cycle with the held fields; no rdata_valid.
REQ-038 Read with mem_rdata_valid never asserted, TIMEOUT_CYCLES=8 -> requester receives 0xDEADBEEF with one rdata_valid pulse, then IDLE.
REQ-039 rst asserted during WAIT_READ -> next cycle both ready=1, no rdata_valid, mem_cmd_start=0; the next simultaneous request is granted to D.
